// File: rtl/uart_rx_frame_check.sv
// Serial UART RX frame checker: deserialises the data field, checks parity and stop bits,
// and keeps saturating parity/stop error counters.
module uart_rx_frame_check #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  input  logic                  par_en,
  input  logic [1:0]            par_mode,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  stop2,
  input  logic                  clr_cnt,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done,
  output logic                  par_err,
  output logic                  stop_err,
  output logic [CNT_W-1:0]      par_err_cnt,
  output logic [CNT_W-1:0]      stop_err_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q;
  logic                  pen_q;
  logic [1:0]            pmode_q;
  logic [LEN_W-1:0]      len_q;
  logic                  stop2_q;
  logic [LEN_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  acc_q;
  logic                  par_flag_q;
  logic                  stop_flag_q;
  logic                  stop_idx_q;

  logic [LEN_W-1:0]      len_clamped;
  logic [DATA_WIDTH-1:0] shift_ins;
  logic                  exp_par;
  logic                  last_stop;
  logic                  stop_err_now;
  logic                  done_now;
  logic                  inc_par;
  logic                  inc_stop;

  always_comb begin
    len_clamped = data_len;
    if (data_len < LEN_W'(5)) begin
      len_clamped = LEN_W'(5);
    end else if (data_len > LEN_W'(DATA_WIDTH)) begin
      len_clamped = LEN_W'(DATA_WIDTH);
    end
  end

  // Place the incoming bit at its field position so the first bit lands in the LSB.
  always_comb begin
    shift_ins = shift_q;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (bit_cnt_q == LEN_W'(i)) begin
        shift_ins[i] = bit_in;
      end
    end
  end

  always_comb begin
    exp_par = 1'b0;
    case (pmode_q)
      2'b00:   exp_par = acc_q;
      2'b01:   exp_par = ~acc_q;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  assign last_stop    = (stop_idx_q == stop2_q);
  assign stop_err_now = stop_flag_q | ~bit_in;
  assign done_now     = (state_q == StStop) && bit_valid && !start && last_stop;
  assign inc_par      = done_now & par_flag_q;
  assign inc_stop     = done_now & stop_err_now;
  assign busy         = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pen_q        <= 1'b0;
      pmode_q      <= 2'b00;
      len_q        <= '0;
      stop2_q      <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      par_flag_q   <= 1'b0;
      stop_flag_q  <= 1'b0;
      stop_idx_q   <= 1'b0;
      data_out     <= '0;
      frame_done   <= 1'b0;
      par_err      <= 1'b0;
      stop_err     <= 1'b0;
      par_err_cnt  <= '0;
      stop_err_cnt <= '0;
    end else begin
      frame_done <= 1'b0;

      if (clr_cnt) begin
        par_err_cnt <= '0;
      end else if (inc_par && (par_err_cnt != {CNT_W{1'b1}})) begin
        par_err_cnt <= par_err_cnt + CNT_W'(1);
      end

      if (clr_cnt) begin
        stop_err_cnt <= '0;
      end else if (inc_stop && (stop_err_cnt != {CNT_W{1'b1}})) begin
        stop_err_cnt <= stop_err_cnt + CNT_W'(1);
      end

      // start always wins: it aborts any frame in progress and swallows a coincident bit.
      if (start) begin
        state_q     <= StData;
        pen_q       <= par_en;
        pmode_q     <= par_mode;
        len_q       <= len_clamped;
        stop2_q     <= stop2;
        bit_cnt_q   <= '0;
        shift_q     <= '0;
        acc_q       <= 1'b0;
        par_flag_q  <= 1'b0;
        stop_flag_q <= 1'b0;
        stop_idx_q  <= 1'b0;
      end else if (bit_valid) begin
        case (state_q)
          StIdle: begin
          end
          StData: begin
            shift_q <= shift_ins;
            acc_q   <= acc_q ^ bit_in;
            if (bit_cnt_q == (len_q - LEN_W'(1))) begin
              bit_cnt_q <= '0;
              state_q   <= pen_q ? StParity : StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + LEN_W'(1);
            end
          end
          StParity: begin
            par_flag_q <= (bit_in != exp_par);
            state_q    <= StStop;
          end
          StStop: begin
            if (last_stop) begin
              state_q     <= StIdle;
              frame_done  <= 1'b1;
              data_out    <= shift_q;
              par_err     <= par_flag_q;
              stop_err    <= stop_err_now;
              stop_idx_q  <= 1'b0;
              stop_flag_q <= 1'b0;
            end else begin
              stop_flag_q <= stop_err_now;
              stop_idx_q  <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: directed frame table, abort/counter/reset sequences,
// and randomized frames checked against a rule-level reference model.
module tb_uart_rx_frame_check;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       par_en = 1'b0;
  logic [1:0] par_mode = 2'b00;
  logic [3:0] data_len = 4'd8;
  logic       stop2 = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       busy;
  logic [7:0] data_out;
  logic       frame_done;
  logic       par_err;
  logic       stop_err;
  logic [1:0] par_err_cnt;
  logic [1:0] stop_err_cnt;

  uart_rx_frame_check #(
    .DATA_WIDTH(8),
    .LEN_W     (4),
    .CNT_W     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .par_en      (par_en),
    .par_mode    (par_mode),
    .data_len    (data_len),
    .stop2       (stop2),
    .clr_cnt     (clr_cnt),
    .busy        (busy),
    .data_out    (data_out),
    .frame_done  (frame_done),
    .par_err     (par_err),
    .stop_err    (stop_err),
    .par_err_cnt (par_err_cnt),
    .stop_err_cnt(stop_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       pen;
    logic [1:0] pm;
    logic [3:0] len;
    logic       s2;
    logic [7:0] data;
    logic       pbit;
    logic [1:0] stops;  // [0] first stop bit, [1] second
    logic [7:0] exp_d;
    logic       exp_p;
    logic       exp_s;
  } vec_t;

  vec_t tbl[8];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   m_par = 0;
  int   m_stop = 0;

  always @(negedge clk) if (frame_done === 1'b1) n_done++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff_len(input logic [3:0] len);
    if (len < 5) return 5;
    if (len > 8) return 8;
    return int'(len);
  endfunction

  task automatic ref_model(input logic pen, input logic [1:0] pm, input logic [3:0] len,
                           input logic s2, input logic [7:0] data, input logic pbit,
                           input logic [1:0] stops, output logic [7:0] exp_d,
                           output logic exp_p, output logic exp_s);
    int   ones;
    logic want;
    exp_d = data & 8'((1 << eff_len(len)) - 1);
    ones  = $countones(exp_d);
    case (pm)
      2'd0:    want = 1'(ones % 2);
      2'd1:    want = 1'(1 - ones % 2);
      2'd2:    want = 1'b1;
      default: want = 1'b0;
    endcase
    exp_p = pen && (pbit != want);
    exp_s = (stops[0] == 1'b0) || (s2 && stops[1] == 1'b0);
  endtask

  task automatic send_frame(input string name, input logic pen, input logic [1:0] pm,
                            input logic [3:0] len, input logic s2, input logic [7:0] data,
                            input logic pbit, input logic [1:0] stops, input logic clr_last,
                            input logic [7:0] exp_d, input logic exp_p, input logic exp_s);
    logic q[$];
    int   gap;
    for (int i = 0; i < eff_len(len); i++) q.push_back(data[i]);
    if (pen) q.push_back(pbit);
    q.push_back(stops[0]);
    if (s2) q.push_back(stops[1]);

    @(negedge clk);
    start     = 1'b1;
    par_en    = pen;
    par_mode  = pm;
    data_len  = len;
    stop2     = s2;
    bit_valid = 1'($urandom);
    bit_in    = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    check({name, "/busy"}, 32'(busy), 32'd1);
    // Scramble config mid-frame; the latched copy must be used.
    par_en   = 1'($urandom);
    par_mode = 2'($urandom);
    data_len = 4'($urandom);
    stop2    = 1'($urandom);

    for (int i = 0; i < q.size(); i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        bit_valid = 1'b0;
        @(negedge clk);
      end
      bit_valid = 1'b1;
      bit_in    = q[i];
      clr_cnt   = clr_last && (i == q.size() - 1);
      @(negedge clk);
    end
    bit_valid = 1'b0;
    clr_cnt   = 1'b0;

    if (clr_last) begin
      m_par  = 0;
      m_stop = 0;
    end else begin
      if (exp_p && m_par < 3) m_par++;
      if (exp_s && m_stop < 3) m_stop++;
    end
    check({name, "/frame_done"}, 32'(frame_done), 32'd1);
    check({name, "/data_out"}, 32'(data_out), 32'(exp_d));
    check({name, "/par_err"}, 32'(par_err), 32'(exp_p));
    check({name, "/stop_err"}, 32'(stop_err), 32'(exp_s));
    check({name, "/par_err_cnt"}, 32'(par_err_cnt), 32'(m_par));
    check({name, "/stop_err_cnt"}, 32'(stop_err_cnt), 32'(m_stop));
    check({name, "/idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({name, "/done_pulse"}, 32'(frame_done), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input logic clr_last);
    send_frame(v.name, v.pen, v.pm, v.len, v.s2, v.data, v.pbit, v.stops, clr_last,
               v.exp_d, v.exp_p, v.exp_s);
  endtask

  initial begin
    int         d0;
    logic       pen, s2, pbit, clr;
    logic [1:0] pm, stops;
    logic [3:0] len;
    logic [7:0] data, exp_d;
    logic       exp_p, exp_s;

    tbl[0] = '{"t1_8n1",      1'b0, 2'd0, 4'd8,  1'b0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{"t2_8e1_bad",  1'b1, 2'd0, 4'd8,  1'b0, 8'h07, 1'b0, 2'b11, 8'h07, 1'b1, 1'b0};
    tbl[2] = '{"t2_8e1_good", 1'b1, 2'd0, 4'd8,  1'b0, 8'h07, 1'b1, 2'b11, 8'h07, 1'b0, 1'b0};
    tbl[3] = '{"t3_7o2",      1'b1, 2'd1, 4'd7,  1'b1, 8'h3F, 1'b1, 2'b01, 8'h3F, 1'b0, 1'b1};
    tbl[4] = '{"t4_mark",     1'b1, 2'd2, 4'd5,  1'b0, 8'h1F, 1'b0, 2'b11, 8'h1F, 1'b1, 1'b0};
    tbl[5] = '{"t4_space_l3", 1'b1, 2'd3, 4'd3,  1'b0, 8'h15, 1'b0, 2'b11, 8'h15, 1'b0, 1'b0};
    tbl[6] = '{"len12_e2",    1'b1, 2'd0, 4'd12, 1'b1, 8'hC3, 1'b0, 2'b00, 8'hC3, 1'b0, 1'b1};
    tbl[7] = '{"6o1_both",    1'b1, 2'd1, 4'd6,  1'b0, 8'h2A, 1'b1, 2'b10, 8'h2A, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/data_out", 32'(data_out), 32'd0);
    check("reset/frame_done", 32'(frame_done), 32'd0);
    check("reset/errs", {30'd0, par_err, stop_err}, 32'd0);
    check("reset/cnts", {28'd0, par_err_cnt, stop_err_cnt}, 32'd0);
    rst = 1'b1;

    // Idle bit_valid must be ignored.
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    @(negedge clk);
    bit_valid = 1'b0;
    check("idle_bit/busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], 1'b0);

    // Abort: 4 data bits, then a restart with a full 8N1 frame of 0x5A.
    d0 = n_done;
    @(negedge clk);
    start    = 1'b1;
    par_en   = 1'b0;
    data_len = 4'd8;
    stop2    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom);
      @(negedge clk);
    end
    bit_valid = 1'b0;
    send_frame("t5_abort", 1'b0, 2'd0, 4'd8, 1'b0, 8'h5A, 1'b0, 2'b11, 1'b0,
               8'h5A, 1'b0, 1'b0);
    #1;
    check("t5_abort/done_count", 32'(n_done - d0), 32'd1);

    // Counter clear, saturation, and clear winning over a coincident increment.
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    m_par   = 0;
    m_stop  = 0;
    check("t6_clr/cnts", {28'd0, par_err_cnt, stop_err_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) run_vec(tbl[1], 1'b0);
    check("t6_sat/par_err_cnt", 32'(par_err_cnt), 32'd3);
    run_vec(tbl[1], 1'b1);
    check("t6_clr_wins/par_err_cnt", 32'(par_err_cnt), 32'd0);

    // Reset mid-frame discards the frame and clears everything.
    run_vec(tbl[7], 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    rst = 1'b0;
    #1;
    m_par  = 0;
    m_stop = 0;
    check("t6_rst/busy", 32'(busy), 32'd0);
    check("t6_rst/data_out", 32'(data_out), 32'd0);
    check("t6_rst/errs", {30'd0, par_err, stop_err}, 32'd0);
    check("t6_rst/cnts", {28'd0, par_err_cnt, stop_err_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(tbl[0], 1'b0);

    for (int n = 0; n < 40; n++) begin
      pen   = 1'($urandom);
      pm    = 2'($urandom);
      len   = 4'($urandom);
      s2    = 1'($urandom);
      data  = 8'($urandom);
      pbit  = 1'($urandom);
      stops = 2'($urandom);
      clr   = ($urandom % 8) == 0;
      ref_model(pen, pm, len, s2, data, pbit, stops, exp_d, exp_p, exp_s);
      if ($urandom % 4 == 0) begin
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = 1'($urandom);
        @(negedge clk);
        bit_valid = 1'b0;
      end
      send_frame($sformatf("rand%0d", n), pen, pm, len, s2, exp_d, pbit, stops, clr,
                 exp_d, exp_p, exp_s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
